// File: rtl/state_pkg.sv
// rtl/state_pkg.sv - shared jump states and PS/2 scancode constants
package state_pkg;

    // Vertical motion phases of the player sprite
    typedef enum logic [1:0] {
        GROUND,
        RISE,
        FALL
    } jump_state_t;

    // Set-2 scancodes for the movement keys and the prefix bytes
    localparam logic [7:0] KEY_LEFT  = 8'h1C;
    localparam logic [7:0] KEY_RIGHT = 8'h23;
    localparam logic [7:0] KEY_JUMP  = 8'h29;
    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;

endpackage

// File: rtl/ps2_key_tracker.sv
// rtl/ps2_key_tracker.sv - make/break tracking of movement keys and jump request latch
module ps2_key_tracker
    import state_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] key_code,
    input  logic       key_valid,
    input  logic       frame,
    output logic       left_held,
    output logic       right_held,
    output logic       jump_req
);

    logic brk_q;
    logic ext_q;
    logic left_q;
    logic right_q;
    logic space_q;
    logic jump_req_q;

    // Decode scancode stream; a jump set on the same edge as a frame clear wins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            brk_q      <= 1'b0;
            ext_q      <= 1'b0;
            left_q     <= 1'b0;
            right_q    <= 1'b0;
            space_q    <= 1'b0;
            jump_req_q <= 1'b0;
        end else begin
            if (frame) begin
                jump_req_q <= 1'b0;
            end
            if (key_valid) begin
                if (key_code == SC_BREAK) begin
                    brk_q <= 1'b1;
                end else if (key_code == SC_EXT) begin
                    ext_q <= 1'b1;
                end else begin
                    // Extended keys (arrows etc.) share codes with A/D/space; drop them
                    if (!ext_q) begin
                        case (key_code)
                            KEY_LEFT:  left_q  <= !brk_q;
                            KEY_RIGHT: right_q <= !brk_q;
                            KEY_JUMP: begin
                                space_q <= !brk_q;
                                // Only a fresh press requests a jump; typematic repeats do not
                                if (!brk_q && !space_q) begin
                                    jump_req_q <= 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                    brk_q <= 1'b0;
                    ext_q <= 1'b0;
                end
            end
        end
    end

    assign left_held  = left_q;
    assign right_held = right_q;
    assign jump_req   = jump_req_q;

endmodule

// File: rtl/player_motion_sched.sv
// rtl/player_motion_sched.sv - per-frame player position sequencer (walk + jump/gravity)
module player_motion_sched
    import state_pkg::*;
#(
    parameter logic [11:0] X_MIN    = 12'd0,
    parameter logic [11:0] X_MAX    = 12'd756,
    parameter logic [11:0] X_START  = 12'd378,
    parameter logic [11:0] Y_GROUND = 12'd600,
    parameter logic [11:0] STEP     = 12'd2,
    parameter logic [5:0]  JUMP_V0  = 6'd12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        v_tick,
    input  logic [7:0]  key_code,
    input  logic        key_valid,
    output logic [11:0] player_xpos,
    output logic [11:0] player_ypos,
    output logic        airborne
);

    logic        v_tick_q;
    logic        frame;
    logic        left_held;
    logic        right_held;
    logic        jump_req;

    logic [11:0] x_q;
    logic [11:0] x_d;
    logic [11:0] y_q;
    logic [5:0]  vel_q;
    jump_state_t state_q;

    // 13-bit intermediates so the clamps never see a wrapped sum
    logic [12:0] x_right_sum;
    logic [12:0] x_left_lim;
    logic [12:0] y_fall_sum;
    logic [11:0] vel_ext;
    logic [5:0]  vel_dec;

    ps2_key_tracker u_keys (
        .clk        (clk),
        .rst        (rst),
        .key_code   (key_code),
        .key_valid  (key_valid),
        .frame      (frame),
        .left_held  (left_held),
        .right_held (right_held),
        .jump_req   (jump_req)
    );

    // Remember previous v_tick level so a long-held tick yields a single frame pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_tick_q <= 1'b0;
        end else begin
            v_tick_q <= v_tick;
        end
    end

    assign frame = v_tick & ~v_tick_q;

    assign x_right_sum = {1'b0, x_q} + {1'b0, STEP};
    assign x_left_lim  = {1'b0, X_MIN} + {1'b0, STEP};

    // Horizontal step: one direction moves with clamping, both or neither holds
    always_comb begin
        x_d = x_q;
        if (frame) begin
            if (right_held && !left_held) begin
                x_d = (x_right_sum > {1'b0, X_MAX}) ? X_MAX : x_right_sum[11:0];
            end else if (left_held && !right_held) begin
                x_d = ({1'b0, x_q} < x_left_lim) ? X_MIN : (x_q - STEP);
            end
        end
    end

    // Horizontal position register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q <= X_START;
        end else begin
            x_q <= x_d;
        end
    end

    assign vel_ext    = {6'd0, vel_q};
    assign vel_dec    = vel_q - 6'd1;
    assign y_fall_sum = {1'b0, y_q} + {1'b0, vel_ext};

    // Jump/gravity FSM: decelerating rise, accelerating fall capped at JUMP_V0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= GROUND;
            y_q     <= Y_GROUND;
            vel_q   <= 6'd0;
        end else if (frame) begin
            case (state_q)
                GROUND: begin
                    // Take-off frame only loads velocity; y moves from the next frame
                    if (jump_req) begin
                        vel_q   <= JUMP_V0;
                        state_q <= RISE;
                    end
                end
                RISE: begin
                    y_q <= (y_q < vel_ext) ? 12'd0 : (y_q - vel_ext);
                    if (vel_dec == 6'd0) begin
                        state_q <= FALL;
                        vel_q   <= 6'd1;
                    end else begin
                        vel_q   <= vel_dec;
                    end
                end
                FALL: begin
                    if (y_fall_sum >= {1'b0, Y_GROUND}) begin
                        y_q     <= Y_GROUND;
                        vel_q   <= 6'd0;
                        state_q <= GROUND;
                    end else begin
                        y_q   <= y_fall_sum[11:0];
                        vel_q <= (vel_q >= JUMP_V0) ? JUMP_V0 : (vel_q + 6'd1);
                    end
                end
                default: begin
                    state_q <= GROUND;
                end
            endcase
        end
    end

    assign player_xpos = x_q;
    assign player_ypos = y_q;
    assign airborne    = (state_q != GROUND);

endmodule

// File: tb/tb_player_motion_sched.sv
// tb/tb_player_motion_sched.sv - directed self-checking bench for player_motion_sched
module tb_player_motion_sched;

    logic        clk;
    logic        rst;
    logic        v_tick;
    logic [7:0]  key_code;
    logic        key_valid;
    logic [11:0] player_xpos;
    logic [11:0] player_ypos;
    logic        airborne;

    int total;
    int bad;

    int exp_y[24];
    int exp_x;

    player_motion_sched dut (
        .clk         (clk),
        .rst         (rst),
        .v_tick      (v_tick),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .player_xpos (player_xpos),
        .player_ypos (player_ypos),
        .airborne    (airborne)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout: got no_finish expected finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send_key(input logic [7:0] code);
        @(negedge clk);
        key_code  = code;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        key_code  = 8'h00;
    endtask

    task automatic frame_step();
        @(negedge clk);
        v_tick = 1'b1;
        @(negedge clk);
        v_tick = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_x", 32'(player_xpos), 32'd378);
        check("rst_y", 32'(player_ypos), 32'd600);
        check("rst_air", 32'(airborne), 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        v_tick    = 1'b0;
        key_code  = 8'h00;
        key_valid = 1'b0;
        exp_y = '{588, 577, 567, 558, 550, 543, 537, 532, 528, 525, 523, 522,
                  523, 525, 528, 532, 537, 543, 550, 558, 567, 577, 588, 600};

        repeat (3) @(negedge clk);
        check("reset_x", 32'(player_xpos), 32'd378);
        check("reset_y", 32'(player_ypos), 32'd600);
        check("reset_air", 32'(airborne), 32'd0);
        rst = 1'b0;

        // Idle frames: nothing moves
        for (int i = 0; i < 5; i++) begin
            frame_step();
            check("idle_x", 32'(player_xpos), 32'd378);
            check("idle_y", 32'(player_ypos), 32'd600);
            check("idle_air", 32'(airborne), 32'd0);
        end

        // Right held for 10 frames, then released
        send_key(8'h23);
        for (int i = 1; i <= 10; i++) begin
            frame_step();
            check("right_x", 32'(player_xpos), 32'(378 + 2 * i));
        end
        send_key(8'hF0);
        send_key(8'h23);
        for (int i = 0; i < 3; i++) begin
            frame_step();
            check("right_rel_x", 32'(player_xpos), 32'd398);
        end

        // Right held until the right clamp
        send_key(8'h23);
        for (int i = 1; i <= 200; i++) begin
            frame_step();
            if (i == 178) check("right_pre_clamp_x", 32'(player_xpos), 32'd754);
            if (i == 179) check("right_clamp_x", 32'(player_xpos), 32'd756);
        end
        check("right_stick_x", 32'(player_xpos), 32'd756);
        send_key(8'hF0);
        send_key(8'h23);

        // Both held: hold; release left: move right
        do_reset();
        send_key(8'h1C);
        send_key(8'h23);
        for (int i = 0; i < 4; i++) begin
            frame_step();
            check("both_x", 32'(player_xpos), 32'd378);
        end
        send_key(8'hF0);
        send_key(8'h1C);
        for (int i = 1; i <= 3; i++) begin
            frame_step();
            check("rel_left_x", 32'(player_xpos), 32'(378 + 2 * i));
        end
        send_key(8'hF0);
        send_key(8'h23);

        // Left held until the left clamp; extended 0x1C must not count as left
        exp_x = 384;
        send_key(8'hE0);
        send_key(8'h1C);
        frame_step();
        check("ext_ignored_x", 32'(player_xpos), 32'(exp_x));
        send_key(8'h1C);
        for (int i = 1; i <= 200; i++) begin
            frame_step();
            exp_x = (exp_x < 2) ? 0 : exp_x - 2;
            if (i == 191) check("left_last_step_x", 32'(player_xpos), 32'(exp_x));
        end
        check("left_clamp_x", 32'(player_xpos), 32'd0);
        send_key(8'hF0);
        send_key(8'h1C);

        // Full jump profile
        do_reset();
        send_key(8'h29);
        frame_step();
        check("takeoff_y", 32'(player_ypos), 32'd600);
        check("takeoff_air", 32'(airborne), 32'd1);
        for (int k = 1; k <= 24; k++) begin
            if (k == 5) begin
                send_key(8'h29);
                send_key(8'h29);
                send_key(8'h29);
            end
            frame_step();
            check("jump_y", 32'(player_ypos), 32'(exp_y[k-1]));
            check("jump_air", 32'(airborne), (k < 24) ? 32'd1 : 32'd0);
        end
        check("jump_x", 32'(player_xpos), 32'd378);

        // Repeats during the jump and after landing must not relaunch
        for (int i = 0; i < 3; i++) begin
            frame_step();
            check("no_rejump_air", 32'(airborne), 32'd0);
            check("no_rejump_y", 32'(player_ypos), 32'd600);
        end
        send_key(8'h29);
        frame_step();
        check("typematic_air", 32'(airborne), 32'd0);

        // Release then fresh press: new jump
        send_key(8'hF0);
        send_key(8'h29);
        send_key(8'h29);
        frame_step();
        check("rejump_air", 32'(airborne), 32'd1);
        check("rejump_y0", 32'(player_ypos), 32'd600);
        frame_step();
        check("rejump_y1", 32'(player_ypos), 32'd588);

        // Long v_tick high gives one update
        do_reset();
        send_key(8'h23);
        @(negedge clk);
        v_tick = 1'b1;
        repeat (100) @(negedge clk);
        v_tick = 1'b0;
        @(negedge clk);
        check("long_tick_x", 32'(player_xpos), 32'd380);
        send_key(8'hF0);
        send_key(8'h23);

        // Key event coinciding with the frame edge: effect lands next frame
        do_reset();
        @(negedge clk);
        v_tick    = 1'b1;
        key_code  = 8'h1C;
        key_valid = 1'b1;
        @(negedge clk);
        v_tick    = 1'b0;
        key_valid = 1'b0;
        @(negedge clk);
        check("coincide_x0", 32'(player_xpos), 32'd378);
        frame_step();
        check("coincide_x1", 32'(player_xpos), 32'd376);
        send_key(8'hF0);
        send_key(8'h1C);

        // Space make coinciding with the frame edge is kept for the next frame
        @(negedge clk);
        v_tick    = 1'b1;
        key_code  = 8'h29;
        key_valid = 1'b1;
        @(negedge clk);
        v_tick    = 1'b0;
        key_valid = 1'b0;
        @(negedge clk);
        check("coincide_jump_air0", 32'(airborne), 32'd0);
        frame_step();
        check("coincide_jump_air1", 32'(airborne), 32'd1);

        // Reset in mid-rise while moving right
        send_key(8'h23);
        frame_step();
        frame_step();
        frame_step();
        check("midrise_y", 32'(player_ypos), 32'd567);
        check("midrise_x", 32'(player_xpos), 32'd382);
        do_reset();
        frame_step();
        check("post_rst_air", 32'(airborne), 32'd0);
        check("post_rst_y", 32'(player_ypos), 32'd600);
        check("post_rst_x", 32'(player_xpos), 32'd378);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/player_motion_sched.md
# player_motion_sched

Frame-rate motion scheduler for the local player sprite. It consumes PS/2 scancode bytes and tracks make/break state of the movement keys. Once per frame (rising edge of `v_tick`) it sequences the player position registers: horizontal stepping with clamping, plus a three-state jump/gravity sequence. It sits between the keyboard receiver and the sprite draw stage, and owns `player_xpos`/`player_ypos`.

## Interface
- `X_MIN`, 0, left clamp (pixels)
- `X_MAX`, 756, right clamp
- `X_START`, 378, reset x
- `Y_GROUND`, 600, ground y (larger y = lower)
- `STEP`, 2, horizontal pixels per frame
- `JUMP_V0`, 12, initial jump velocity (px/frame); also the fall-speed cap
- `clk`  in  1  system clock
- `rst`  in  1  reset, asynchronous, active-high
- `v_tick`  in  1  frame tick level, asynchronous to frame phase; only rising edges count
- `key_code`  in  8  PS/2 scancode byte
- `key_valid`  in  1  one-cycle strobe; `key_code` valid
- `player_xpos`  out  12  sprite x
- `player_ypos`  out  12  sprite y
- `airborne`  out  1  high while not in GROUND

## Operation
- Scancode tracking, per `key_valid`:
  - 0xF0 sets `brk`.
  - 0xE0 sets `ext`.
  - Any other byte: if `ext`, the byte is ignored. Otherwise, for 0x1C (A, left), 0x23 (D, right) or 0x29 (space), the held flag is set to `!brk`. Then `brk` and `ext` clear.
- `jump_req` latches on a space make when space is not already held, so typematic repeat is filtered. It clears on every frame tick, whether consumed or not.
- Frame tick: `v_tick_d` is registered from `v_tick`; `frame = v_tick & ~v_tick_d`.
- Horizontal, on frame:
  - right only: x = min(x+STEP, X_MAX)
  - left only: x = (x < X_MIN+STEP) ? X_MIN : x−STEP
  - both or neither: hold
- Vertical FSM (`jump_state_t`), on frame; `vel` is 6-bit unsigned:
  - GROUND: if `jump_req`, set vel=JUMP_V0 and go to RISE. y is unchanged this frame.
  - RISE: y = (y < vel) ? 0 : y−vel, then vel−1. When vel reaches 0, go to FALL with vel=1 for the next frame.
  - FALL: if y+vel ≥ Y_GROUND, set y=Y_GROUND, vel=0 and go to GROUND. Otherwise y += vel and vel = min(vel+1, JUMP_V0).
- The horizontal and vertical updates apply in the same frame, independently.
- Arithmetic uses 12-bit unsigned values, with comparisons made at 13 bits to avoid wrap.
- Reset (any time, including mid-jump): x=X_START, y=Y_GROUND, state GROUND, vel=0, all held flags, `brk`, `ext`, `jump_req` and `v_tick_d` = 0, `airborne`=0.

## Timing
- Outputs are registered. Position changes on the clock edge where `frame` is high, i.e. 1 clk after `v_tick` is first sampled high.
- At most one position update per `v_tick` rising edge, however long `v_tick` stays high.
- Held flags and `jump_req` update on the edge where `key_valid` is high.
- If `key_valid` and `frame` coincide, the frame update uses the pre-edge flags, and the key event takes effect next frame. In that case a space-make `jump_req` is not lost: the set wins over the frame clear.
- `airborne` is decoded from registered state: zero latency relative to the state change.
- Jump with JUMP_V0=12:
  - 12 RISE frames, apex Y_GROUND−78.
  - 12 FALL frames, landing on the 12th with y clamped to 600.

## Structure
- `state_pkg` gets:
  - `typedef enum logic [1:0] {GROUND, RISE, FALL} jump_state_t`
  - scancode constants `KEY_LEFT`=8'h1C, `KEY_RIGHT`=8'h23, `KEY_JUMP`=8'h29, `SC_BREAK`=8'hF0, `SC_EXT`=8'hE0
- Sub-module `ps2_key_tracker`: contains the `brk`/`ext`/held flags and `jump_req`. Its outputs are `left_held`, `right_held`, `jump_req`, and it takes `frame` as the clear input.
- The top level contains the edge detector, the horizontal datapath and the vertical FSM.

## Test plan
- Reset then idle 5 frames → x=378, y=600, `airborne`=0 throughout.
- 0x23 make, 10 frames, then F0 23 → x=398 after 10 frames, then static. Right held for 200 frames → x sticks at 756.
- Both 0x1C and 0x23 made → x unchanged over 4 frames. Then F0 1C → x increases 2/frame.
- 0x29 make, 24 frames →
  - RISE y sequence 588,577,…,522 (apex);
  - FALL back down, landing at y=600 in the 24th frame;
  - `airborne` high during frames 1–23 after takeoff.
- Space repeat 0x29,0x29,0x29 mid-jump, then landing → no second jump. Then F0 29 and 0x29 → new jump.
- `v_tick` held high 100 clks → one update only. `key_valid`=0x1C in the same cycle as `frame` → x is unaffected this frame and moves on the next. Reset asserted mid-RISE → x=378, y=600, GROUND immediately.
